// File: rtl/sseg_display_sched.sv
// Round-robin scheduler that time-shares a 4-digit active-low seven-segment display between two requesters.
// Optional macro SSEG_SCHED_BLANK_SWITCH_EN inserts one blank frame on every owner handoff.
module sseg_display_sched #(
    parameter int unsigned SCAN_N      = 16,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    input  logic [7:0] a_sseg0,
    input  logic [7:0] a_sseg1,
    input  logic [7:0] a_sseg2,
    input  logic [7:0] a_sseg3,
    input  logic [7:0] b_sseg0,
    input  logic [7:0] b_sseg1,
    input  logic [7:0] b_sseg2,
    input  logic [7:0] b_sseg3,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int unsigned CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_FRAMES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GA   = 2'd1;
    localparam logic [1:0] ST_GB   = 2'd2;
`ifdef SSEG_SCHED_BLANK_SWITCH_EN
    localparam logic [1:0] ST_SW   = 2'd3;
`endif

    logic [SCAN_N-1:0] presc_q, presc_d;
    logic [1:0]        digit_q, digit_d;
    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic              slot_tick, frame_tick;
    logic              owner_b, own_req, oth_req;
    logic [CNT_W-1:0]  cnt_inc;
    logic [7:0]        pat_a, pat_b;

    // Prefer the requester that was not served last; fall back to the previous one.
    function automatic logic [1:0] pick_owner(input logic prev_b, input logic [1:0] r);
        pick_owner = ST_IDLE;
        if (r[!prev_b]) pick_owner = prev_b ? ST_GA : ST_GB;
        else if (r[prev_b]) pick_owner = prev_b ? ST_GB : ST_GA;
    endfunction

    always_comb begin
        pat_a = a_sseg0;
        pat_b = b_sseg0;
        case (digit_q)
            2'd1: begin pat_a = a_sseg1; pat_b = b_sseg1; end
            2'd2: begin pat_a = a_sseg2; pat_b = b_sseg2; end
            2'd3: begin pat_a = a_sseg3; pat_b = b_sseg3; end
            default: ;
        endcase
    end

    always_comb begin
        presc_d    = presc_q + SCAN_N'(1);
        slot_tick  = &presc_q;
        frame_tick = slot_tick && (digit_q == 2'd3);
        digit_d    = slot_tick ? digit_q + 2'd1 : digit_q;

        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        owner_b = (state_q == ST_GB);
        own_req = req[owner_b];
        oth_req = req[!owner_b];
        cnt_inc = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        // Ownership only moves on frame boundaries so a frame never mixes sources.
        if (frame_tick) begin
            case (state_q)
                ST_IDLE: state_d = pick_owner(last_q, req);
                ST_GA, ST_GB: begin
                    if (!own_req || (oth_req && cnt_inc == HOLD_MAX)) begin
`ifdef SSEG_SCHED_BLANK_SWITCH_EN
                        state_d = oth_req ? ST_SW : ST_IDLE;
`else
                        state_d = pick_owner(owner_b, req);
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`ifdef SSEG_SCHED_BLANK_SWITCH_EN
                ST_SW: state_d = pick_owner(last_q, req);
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        if ((state_d == ST_GA || state_d == ST_GB) && state_d != state_q) begin
            cnt_d  = '0;
            last_d = (state_d == ST_GB);
        end

        grant_d = {state_d == ST_GB, state_d == ST_GA};

        an_d  = 4'hF;
        seg_d = 8'hFF;
        if (state_q == ST_GA) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = pat_a;
        end else if (state_q == ST_GB) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = pat_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            digit_q <= 2'd0;
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            grant_q <= 2'b00;
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign grant = grant_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_sseg_display_sched.sv
// Directed bench for sseg_display_sched with SCAN_N=2 (16-cycle frames) and HOLD_FRAMES=2.
module tb_sseg_display_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] grant;
    logic [7:0] a_sseg0, a_sseg1, a_sseg2, a_sseg3;
    logic [7:0] b_sseg0, b_sseg1, b_sseg2, b_sseg3;
    logic [3:0] an;
    logic [7:0] seg;

    int n_checks;
    int n_fail;
    int k;

    logic [3:0] an_tab [4];
    logic [7:0] pa_tab [4];

    sseg_display_sched #(.SCAN_N(2), .HOLD_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .a_sseg0(a_sseg0), .a_sseg1(a_sseg1), .a_sseg2(a_sseg2), .a_sseg3(a_sseg3),
        .b_sseg0(b_sseg0), .b_sseg1(b_sseg1), .b_sseg2(b_sseg2), .b_sseg3(b_sseg3),
        .an(an), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // k counts rising edges since the last reset release; sampling is 1 time unit after the edge.
    task automatic goto(input int target);
        while (k < target) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 8'(grant), 8'h00);
        chk("rst_an", 8'(an), 8'h0F);
        chk("rst_seg", seg, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        k        = 0;
        rst      = 1'b1;
        req      = 2'b00;
        an_tab   = '{4'hE, 4'hD, 4'hB, 4'h7};
        pa_tab   = '{8'h9C, 8'hFF, 8'hA3, 8'h00};
        a_sseg0 = 8'h9C; a_sseg1 = 8'hFF; a_sseg2 = 8'hA3; a_sseg3 = 8'h00;
        b_sseg0 = 8'h11; b_sseg1 = 8'h22; b_sseg2 = 8'h33; b_sseg3 = 8'h44;

        // Reset and idle: display stays blank for three frames with no requests.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            goto(4 * i);
            chk("idle_an", 8'(an), 8'h0F);
            chk("idle_grant", 8'(grant), 8'h00);
        end

        // Single owner A: grant after first frame_tick, then a full digit scan.
        do_reset();
        req = 2'b01;
        goto(15);
        chk("single_pre_grant", 8'(grant), 8'h00);
        goto(16);
        chk("single_grant", 8'(grant), 8'h01);
        chk("single_an_lag", 8'(an), 8'h0F);
        for (int d = 0; d < 4; d++) begin
            goto(17 + 4 * d);
            chk("single_an", 8'(an), 8'(an_tab[d]));
            chk("single_seg", seg, pa_tab[d]);
        end
        a_sseg0 = 8'h55;
        goto(33);
        chk("pattern_update_an", 8'(an), 8'h0E);
        chk("pattern_update_seg", seg, 8'h55);
        a_sseg0 = 8'h9C;

        // Release mid-frame: grant holds until the frame boundary.
        goto(40);
        req = 2'b00;
        goto(47);
        chk("release_hold", 8'(grant), 8'h01);
        goto(48);
        chk("release_grant", 8'(grant), 8'h00);
        chk("release_last_an", 8'(an), 8'h07);
        chk("release_last_seg", seg, 8'h00);
        goto(49);
        chk("release_an", 8'(an), 8'h0F);
        chk("release_seg", seg, 8'hFF);

        // Tie from reset: A first, B after the hold, then back to A.
        do_reset();
        req = 2'b11;
        goto(16);
        chk("tie_first", 8'(grant), 8'h01);
        goto(47);
        chk("tie_a_hold", 8'(grant), 8'h01);
`ifdef SSEG_SCHED_BLANK_SWITCH_EN
        goto(48);
        chk("tie_switch_grant", 8'(grant), 8'h00);
        goto(50);
        chk("tie_blank_an", 8'(an), 8'h0F);
        chk("tie_blank_seg", seg, 8'hFF);
        goto(63);
        chk("tie_switch_end", 8'(grant), 8'h00);
        goto(64);
        chk("tie_b_grant", 8'(grant), 8'h02);
        goto(66);
        chk("tie_b_an", 8'(an), 8'h0E);
        chk("tie_b_seg", seg, 8'h11);
        goto(95);
        chk("tie_b_hold", 8'(grant), 8'h02);
        goto(96);
        chk("tie_b_switch", 8'(grant), 8'h00);
        goto(112);
        chk("tie_back_a", 8'(grant), 8'h01);
`else
        goto(48);
        chk("tie_b_grant", 8'(grant), 8'h02);
        goto(50);
        chk("tie_b_an", 8'(an), 8'h0E);
        chk("tie_b_seg", seg, 8'h11);
        goto(79);
        chk("tie_b_hold", 8'(grant), 8'h02);
        goto(80);
        chk("tie_back_a", 8'(grant), 8'h01);
`endif

        // Handoff abandoned: B drops during the handoff frame while A keeps requesting.
        do_reset();
        req = 2'b11;
        goto(52);
        req = 2'b01;
        goto(63);
`ifdef SSEG_SCHED_BLANK_SWITCH_EN
        chk("abandon_blank", 8'(grant), 8'h00);
`else
        chk("abandon_b_owner", 8'(grant), 8'h02);
`endif
        goto(64);
        chk("abandon_regrant_a", 8'(grant), 8'h01);
        goto(66);
        chk("abandon_an", 8'(an), 8'h0E);
        chk("abandon_seg", seg, 8'h9C);

        // Asynchronous reset while digit 2 is on screen.
        do_reset();
        req = 2'b01;
        goto(26);
        chk("async_pre_an", 8'(an), 8'h0B);
        chk("async_pre_seg", seg, 8'hA3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_grant", 8'(grant), 8'h00);
        chk("async_an", 8'(an), 8'h0F);
        chk("async_seg", seg, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        goto(15);
        chk("async_restart_pre", 8'(grant), 8'h00);
        goto(16);
        chk("async_restart_grant", 8'(grant), 8'h01);
        goto(17);
        chk("async_restart_an", 8'(an), 8'h0E);
        chk("async_restart_seg", seg, 8'h9C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_display_sched.md
# sseg_display_sched

Time-multiplexing scheduler that shares the 4-digit seven-segment display between two pattern requesters, such as the clockwise-cycle animation and a numeric readout. It arbitrates ownership with a req/grant handshake and round-robin fairness. It scans the four digits one slot at a time and drives the active-low anode and segment pins from the owner's four 8-bit digit patterns. It sits between the pattern generators and the board pins.

## Interface
- SCAN_N, 16: prescaler width; one digit slot lasts 2^SCAN_N cycles.
- HOLD_FRAMES, 4: minimum frames an owner keeps the display before preemption; must be ≥1.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  2  request levels; bit0 = requester A, bit1 = requester B.
- grant  out  2  one-hot owner; 00 when no owner.
- a_sseg0..a_sseg3  in  8 each  requester A digit patterns.
- b_sseg0..b_sseg3  in  8 each  requester B digit patterns.
- Pattern format, A and B: {dp,g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low; bit i = digit i.
- seg  out  8  segment pins, same format as patterns.

## Operation
- Prescaler counts 0..2^SCAN_N−1 and wraps. slot_tick = prescaler at max.
- Digit index (2 bits) increments on slot_tick, wrapping 3→0.
- frame_tick = slot_tick while digit index = 3.
- Arbitration decisions happen only on frame_tick, so a frame never mixes sources.
- States: IDLE, GRANT_A, GRANT_B, SWITCH.
- IDLE → GRANT_x on frame_tick if any req is set.
  - Single requester: that requester wins.
  - Both requesting: winner is the one not served last.
  - Last-served register resets to B, so A wins the first tie.
- GRANT_x:
  - Frame counter resets to 0 on entry and increments on each frame_tick, saturating at HOLD_FRAMES.
  - On frame_tick with req_x low: go to SWITCH if the other requester is requesting, else IDLE.
  - On frame_tick with req_x high, other requesting, and counter = HOLD_FRAMES: go to SWITCH (preemption).
  - Otherwise stay.
  - Last-served is updated to x on entry.
- SWITCH: blanks exactly one frame. On the next frame_tick:
  - grant the other requester if it still requests;
  - else re-grant the previous owner if it still requests;
  - else go to IDLE.
- grant = 01 only in GRANT_A, 10 only in GRANT_B, 00 in IDLE and SWITCH.
- Display:
  - In GRANT_x: an = one-hot-low of digit index (digit 0 → 1110); seg = owner's pattern for that digit.
  - In IDLE and SWITCH: an = 1111, seg = 8'hFF. Prescaler and digit index keep running.
- Requesters may change patterns at any time; changes appear on the next registered update.
- rst mid-operation: immediate return to reset values; any ongoing frame is abandoned.

## Timing
- Reset values:
  - prescaler 0, digit 0, state IDLE, last-served B, frame counter 0
  - grant 00, an 1111, seg 8'hFF
- an, seg and grant are registered.
- State and grant change in the cycle after frame_tick.
- an and seg follow state, digit and pattern inputs with 1-cycle latency.
- Request-to-grant latency:
  - from IDLE: ≤ one frame (4·2^SCAN_N cycles) + 1 cycle.
  - through SWITCH: one additional frame.
- A req pulse that ends before a frame_tick is not seen. Requesters must hold req until granted.
- Deasserting req does not remove grant until the next frame_tick.

## Configuration
- SSEG_SCHED_BLANK_SWITCH_EN defined: SWITCH state present; every handoff between owners inserts one blank frame.
- Not defined: SWITCH is removed and all SWITCH transitions go directly to the next owner on the same frame_tick. Selection uses the same rule: the other requester if requesting, else re-grant the previous owner, else IDLE. Handoff has no blank frame and grant changes directly 01↔10.

## Test plan
All scenarios use SCAN_N=2 (slot = 4 cycles, frame = 16 cycles), HOLD_FRAMES=2, and the macro defined.
- Reset:
  - Stimulus: rst high; req=00.
  - Response: grant=00, an=1111, seg=FF. After release, an stays 1111 for ≥3 frames.
- Single owner:
  - Stimulus: req=01; a_sseg0..3 = 9C, FF, A3, 00.
  - Response: grant=01 one cycle after the first frame_tick. an then cycles 1110, 1101, 1011, 0111 every 4 cycles, with seg = 9C, FF, A3, 00 respectively.
- Tie:
  - Stimulus: req=11 from reset.
  - Response: A granted first. After 2 frames, 1 blank frame (an=1111, grant=00), then grant=10. After 2 more frames, back to A.
- Release:
  - Stimulus: A owner; req drops to 00 mid-frame.
  - Response: grant stays 01 until frame end, then IDLE with an=1111.
- Switch abandon:
  - Stimulus: during SWITCH from A to B, B drops req while A keeps req.
  - Response: A is re-granted after the blank frame.
- Async reset mid-scan:
  - Stimulus: assert rst at digit 2 while granted.
  - Response: same cycle, asynchronously: grant=00, an=1111, seg=FF. Scan restarts at digit 0 after release.
